// File: rtl/ps2_kbd_ascii_if.sv
// ASCII keyboard handshake bundle: level interrupt, head character, overflow pulse and ack.
interface ps2_kbd_ascii_if;
  logic       kbd_int;
  logic [7:0] kbd_data;
  logic       kbd_int_ack;
  logic       kbd_overflow;

  modport master (
    output kbd_int,
    output kbd_data,
    output kbd_overflow,
    input  kbd_int_ack
  );

  modport slave (
    input  kbd_int,
    input  kbd_data,
    input  kbd_overflow,
    output kbd_int_ack
  );
endinterface

// File: rtl/ps2_kbd_ascii.sv
// PS/2 scan-code set 2 receiver, shift/caps tracking, ASCII translation and character FIFO.
// Define KBD_PARITY_CHECK_EN to also reject frames whose odd parity is wrong.
module ps2_kbd_ascii #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic            clk50M,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_kbd_ascii_if.master kbd
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- input conditioning
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q, clk_filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fall, data_bit;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      clk_sync_q      <= 2'b11;
      data_sync_q     <= 2'b11;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2_clk};
      data_sync_q     <= {data_sync_q[0], ps2_data};
      clk_filt_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILTER_CYCLES - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall     = clk_filt_prev_q & ~clk_filt_q;
  assign data_bit = data_sync_q[1];

  // ---------------------------------------------------------------- frame receiver
  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           byte_valid_q, byte_valid_d;
  logic [ToW-1:0] to_cnt_q;
  logic           timeout, frame_ok;

  assign timeout = (to_cnt_q == ToW'(TIMEOUT_CYCLES));

`ifdef KBD_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (fall && state_q == StParity) begin
      parity_q <= data_bit;
    end
  end

  assign frame_ok = data_bit & (^{rx_shift_q, parity_q});
`else
  assign frame_ok = data_bit;
`endif

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      if (fall) begin
        to_cnt_q <= '0;
      end else if (!timeout) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    if (timeout && state_q != StIdle) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_bit) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          rx_shift_d = {data_bit, rx_shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: state_d = StStop;
        StStop: begin
          byte_valid_d = frame_ok;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- scan-code decoder
  // Returns {mapped, ascii}; letters honour shift^caps, digits honour shift only.
  function automatic logic [8:0] map_key(input logic [7:0] code, input logic shift,
                                         input logic caps);
    logic [8:0] res;
    logic       is_letter;
    res       = 9'h000;
    is_letter = 1'b1;
    case (code)
      8'h1C: res = {1'b1, 8'h61};  8'h32: res = {1'b1, 8'h62};  8'h21: res = {1'b1, 8'h63};
      8'h23: res = {1'b1, 8'h64};  8'h24: res = {1'b1, 8'h65};  8'h2B: res = {1'b1, 8'h66};
      8'h34: res = {1'b1, 8'h67};  8'h33: res = {1'b1, 8'h68};  8'h43: res = {1'b1, 8'h69};
      8'h3B: res = {1'b1, 8'h6A};  8'h42: res = {1'b1, 8'h6B};  8'h4B: res = {1'b1, 8'h6C};
      8'h3A: res = {1'b1, 8'h6D};  8'h31: res = {1'b1, 8'h6E};  8'h44: res = {1'b1, 8'h6F};
      8'h4D: res = {1'b1, 8'h70};  8'h15: res = {1'b1, 8'h71};  8'h2D: res = {1'b1, 8'h72};
      8'h1B: res = {1'b1, 8'h73};  8'h2C: res = {1'b1, 8'h74};  8'h3C: res = {1'b1, 8'h75};
      8'h2A: res = {1'b1, 8'h76};  8'h1D: res = {1'b1, 8'h77};  8'h22: res = {1'b1, 8'h78};
      8'h35: res = {1'b1, 8'h79};  8'h1A: res = {1'b1, 8'h7A};
      default: is_letter = 1'b0;
    endcase
    if (is_letter && (shift ^ caps)) res[7:0] = res[7:0] - 8'h20;
    if (!is_letter) begin
      case (code)
        8'h16: res = {1'b1, shift ? 8'h21 : 8'h31};
        8'h1E: res = {1'b1, shift ? 8'h40 : 8'h32};
        8'h26: res = {1'b1, shift ? 8'h23 : 8'h33};
        8'h25: res = {1'b1, shift ? 8'h24 : 8'h34};
        8'h2E: res = {1'b1, shift ? 8'h25 : 8'h35};
        8'h36: res = {1'b1, shift ? 8'h5E : 8'h36};
        8'h3D: res = {1'b1, shift ? 8'h26 : 8'h37};
        8'h3E: res = {1'b1, shift ? 8'h2A : 8'h38};
        8'h46: res = {1'b1, shift ? 8'h28 : 8'h39};
        8'h45: res = {1'b1, shift ? 8'h29 : 8'h30};
        8'h29: res = {1'b1, 8'h20};
        8'h5A: res = {1'b1, 8'h0D};
        8'h66: res = {1'b1, 8'h08};
        8'h0D: res = {1'b1, 8'h09};
        8'h76: res = {1'b1, 8'h1B};
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  logic       brk_q, ext_q, lshift_q, rshift_q, caps_q;
  logic       push_q;
  logic [7:0] push_data_q;
  logic [8:0] key_map;

  assign key_map = map_key(rx_shift_q, lshift_q | rshift_q, caps_q);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
    end else begin
      push_q <= 1'b0;
      if (byte_valid_q) begin
        if (rx_shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (rx_shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (rx_shift_q == 8'h12) lshift_q <= ~brk_q;
          if (rx_shift_q == 8'h59) rshift_q <= ~brk_q;
          if (rx_shift_q == 8'h58 && !brk_q) caps_q <= ~caps_q;
          if (!brk_q && !ext_q && key_map[8]) begin
            push_q      <= 1'b1;
            push_data_q <= key_map[7:0];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- character FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [PtrW:0] count_q, count_d;
  logic          ack_q, ack_rise, pop, push_ok, full, overflow_q;
  logic [7:0]    data_q, data_d;

  assign full       = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign ack_rise   = kbd.kbd_int_ack & ~ack_q;
  assign pop        = ack_rise & (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_q & (~full | pop);
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) count_d = count_q + (PtrW + 1)'(1);
    if (pop && !push_ok) count_d = count_q - (PtrW + 1)'(1);
  end

  always_comb begin
    data_d = data_q;
    if (pop) begin
      if (count_q != (PtrW + 1)'(1)) data_d = mem_q[rd_ptr_nxt];
      else if (push_ok)              data_d = push_data_q;
    end else if (count_q == '0 && push_ok) begin
      data_d = push_data_q;
    end
  end

  always_ff @(posedge clk50M) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      ack_q      <= kbd.kbd_int_ack;
      count_q    <= count_d;
      data_q     <= data_d;
      overflow_q <= push_q & full & ~pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_nxt;
    end
  end

  assign kbd.kbd_int      = (count_q != '0);
  assign kbd.kbd_data     = data_q;
  assign kbd.kbd_overflow = overflow_q;
endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Bench for ps2_kbd_ascii: directed key sequences plus random typing, checked every cycle
// against a queue-based model of the keyboard decoder and character FIFO.
module tb_ps2_kbd_ascii;
  localparam int unsigned Depth   = 8;
  localparam int unsigned Filter  = 8;
  localparam int unsigned Timeout = 2000;
  localparam int          Half    = 15;

  logic clk50M   = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_ascii_if kbd_bus ();

  ps2_kbd_ascii #(
    .FIFO_DEPTH    (Depth),
    .FILTER_CYCLES (Filter),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk50M  (clk50M),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kbd     (kbd_bus)
  );

  always #5 clk50M = ~clk50M;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;
  int         exp_ovf = 0;
  int         ovf_seen = 0;
  bit         settled = 1'b0;
  bit         m_brk, m_ext, m_lsh, m_rsh, m_caps;
  bit         calib_run = 1'b0;
  int         calib = -1;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                   8'h46, 8'h45};
  logic [7:0] digit_shift [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
                                   8'h28, 8'h29};
  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h16, 8'h45, 8'h3E, 8'h12,
                            8'h59, 8'h58, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h05};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic int lookup(input logic [7:0] code, input bit upper, input bit shift);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == code) return (upper ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++) begin
      if (digit_codes[i] == code) return shift ? int'(digit_shift[i]) : (i == 9 ? 'h30 : 'h31 + i);
    end
    case (code)
      8'h29:   return 'h20;
      8'h5A:   return 'h0D;
      8'h66:   return 'h08;
      8'h0D:   return 'h09;
      8'h76:   return 'h1B;
      default: return -1;
    endcase
  endfunction

  task automatic model_update_last();
    if (exp_q.size() > 0) exp_last = exp_q[0];
  endtask

  task automatic model_push(input int ch);
    if (exp_q.size() < Depth) exp_q.push_back(8'(ch));
    else exp_ovf++;
    model_update_last();
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_update_last();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int ch;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      ch = lookup(b, (m_lsh | m_rsh) ^ m_caps, m_lsh | m_rsh);
      if (!m_brk && !m_ext && ch >= 0) model_push(ch);
      if (b == 8'h12) m_lsh = !m_brk;
      if (b == 8'h59) m_rsh = !m_brk;
      if (b == 8'h58 && !m_brk) m_caps = !m_caps;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_last = 8'h00;
    {m_brk, m_ext, m_lsh, m_rsh, m_caps} = '0;
  endtask

  always @(negedge clk50M) begin
    if (settled) begin
      check("kbd_int", kbd_bus.kbd_int, exp_q.size() != 0);
      check("kbd_data", kbd_bus.kbd_data, exp_q.size() > 0 ? exp_q[0] : exp_last);
      check("ovf_idle", kbd_bus.kbd_overflow, 1'b0);
    end
    if (kbd_bus.kbd_overflow) ovf_seen++;
  end

  initial begin
    repeat (90000) @(posedge clk50M);
    $display("FAIL watchdog: got cycle budget exhausted expected $finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  // On the stop bit, ack_at > 0 raises kbd_int_ack so it is sampled on edge ack_at after
  // the raw falling edge; calibration records the edge after which kbd_int first rises.
  task automatic send_bit(input bit b, input bit is_stop, input int ack_at);
    ps2_data = b;
    tick(Half);
    ps2_clk = 1'b0;
    for (int k = 1; k <= Half; k++) begin
      @(posedge clk50M);
      #1;
      if (is_stop) begin
        if (ack_at > 0 && k == ack_at - 1) kbd_bus.kbd_int_ack = 1'b1;
        if (ack_at > 0 && k == ack_at) kbd_bus.kbd_int_ack = 1'b0;
        if (calib_run && kbd_bus.kbd_int && calib < 0) calib = k;
      end
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int ack_at);
    settled = 1'b0;
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 0);
    send_bit((~^b) ^ bad_par, 1'b0, 0);
    send_bit(1'b1, 1'b1, ack_at);
    tick(Half);
    if (ack_at > 0) model_pop();
`ifdef KBD_PARITY_CHECK_EN
    if (!bad_par) model_byte(b);
`else
    model_byte(b);
`endif
    settled = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 1'b0, 0);
    for (int i = 1; i < nbits; i++) send_bit(i[0], 1'b0, 0);
    ps2_data = 1'b1;
  endtask

  task automatic ack_pulse(input int hold);
    kbd_bus.kbd_int_ack = 1'b1;
    @(posedge clk50M);
    #1;
    model_pop();
    if (hold > 1) tick(hold - 1);
    kbd_bus.kbd_int_ack = 1'b0;
    tick(2);
  endtask

  task automatic expect_head(input string name, input logic [7:0] ch);
    check({name, "_int"}, kbd_bus.kbd_int, 1'b1);
    check({name, "_data"}, kbd_bus.kbd_data, ch);
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin
    kbd_bus.kbd_int_ack = 1'b0;
    model_reset();
    tick(5);
    rst = 1'b0;
    tick(1);
    check("rst_int", kbd_bus.kbd_int, 1'b0);
    check("rst_data", kbd_bus.kbd_data, 8'h00);
    check("rst_ovf", kbd_bus.kbd_overflow, 1'b0);
    settled = 1'b1;

    // 'a' press/release; the make frame also calibrates stop-fall to kbd_int latency
    calib_run = 1'b1;
    send_frame(8'h1C, 1'b0, 0);
    calib_run = 1'b0;
    check("latency_found", calib > 0, 1'b1);
    check("latency_bound", calib <= int'(Filter) + 6, 1'b1);
    if (calib < 2) calib = Half;
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    expect_head("press_a", 8'h61);
    ack_pulse(1);
    check("press_a_drained", kbd_bus.kbd_int, 1'b0);

    // shift + a
    send_frame(8'h12, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h12, 1'b0, 0);
    expect_head("shift_a", 8'h41);
    ack_pulse(1);
    check("shift_a_single", kbd_bus.kbd_int, 1'b0);

    // caps on, then '1' unaffected by caps
    send_frame(8'h58, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h58, 1'b0, 0);
    send_frame(8'h16, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h16, 1'b0, 0);
    expect_head("caps_1", 8'h31);
    ack_pulse(4);
    check("held_ack_one_pop", kbd_bus.kbd_int, 1'b0);

    send_frame(8'h12, 1'b0, 0);
    send_frame(8'h16, 1'b0, 0);
    expect_head("shift_1", 8'h21);
    ack_pulse(1);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h12, 1'b0, 0);

    // nine keys into an eight-deep FIFO
    for (int i = 0; i < 9; i++) send_frame(digit_codes[i], 1'b0, 0);
    check("overflow_once", ovf_seen, 1);
    for (int i = 0; i < 8; i++) begin
      expect_head("fifo_order", 8'h31 + 8'(i));
      ack_pulse(1);
    end
    check("fifo_empty", kbd_bus.kbd_int, 1'b0);

    // full FIFO with push and ack on the same edge (caps is on: uppercase)
    for (int i = 0; i < 8; i++) send_frame(letter_codes[i], 1'b0, 0);
    send_frame(letter_codes[8], 1'b0, calib);
    check("coincide_no_ovf", ovf_seen, 1);
    for (int i = 0; i < 8; i++) begin
      expect_head("coincide_order", 8'h42 + 8'(i));
      ack_pulse(1);
    end
    check("coincide_empty", kbd_bus.kbd_int, 1'b0);

    // partial frame abandoned by timeout, then space
    send_partial(5);
    tick(int'(Timeout) * 6 / 5);
    send_frame(8'h29, 1'b0, 0);
    expect_head("timeout_space", 8'h20);
    ack_pulse(1);
    check("timeout_single", kbd_bus.kbd_int, 1'b0);

    // caps off, then 'a' with corrupted parity
    send_frame(8'h58, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h58, 1'b0, 0);
    send_frame(8'h1C, 1'b1, 0);
`ifdef KBD_PARITY_CHECK_EN
    check("bad_parity_dropped", kbd_bus.kbd_int, 1'b0);
`else
    expect_head("bad_parity_kept", 8'h61);
    ack_pulse(1);
`endif

    // reset mid-frame with caps on and a character queued
    send_frame(8'h58, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    expect_head("pre_reset", 8'h41);
    send_partial(5);
    settled = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    tick(1);
    settled = 1'b1;
    check("mid_rst_int", kbd_bus.kbd_int, 1'b0);
    check("mid_rst_data", kbd_bus.kbd_data, 8'h00);
    tick(4 * Half);
    check("mid_rst_no_output", kbd_bus.kbd_int, 1'b0);
    send_frame(8'h32, 1'b0, 0);
    expect_head("post_rst_b", 8'h62);
    ack_pulse(1);

    // random typing
    for (int t = 0; t < 40; t++) begin
      int         sel;
      logic [7:0] code;
      sel  = int'($urandom_range(0, 99));
      code = pool[$urandom_range(0, 15)];
      if (sel < 10) send_frame(8'hE0, 1'b0, 0);
      if (sel % 3 == 0) send_frame(8'hF0, 1'b0, 0);
      send_frame(code, 1'b0, 0);
      if ($urandom_range(0, 2) == 0) ack_pulse(int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < int'(Depth); i++) ack_pulse(1);
    check("final_empty", kbd_bus.kbd_int, 1'b0);
    check("overflow_count", ovf_seen, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ascii.md
# ps2_kbd_ascii

PS/2 keyboard front end that drives the system's ASCII keyboard interface (`kbd_int`, `kbd_data`, `kbd_int_ack`). It receives scan-code set 2 frames from the PS/2 device and tracks shift and caps-lock state. It translates key presses to 8-bit ASCII and queues them in a small FIFO, presenting each character to the memory controller through a level interrupt and an ack handshake. It runs entirely in the `clk50M` domain, alongside `serial_port` and `vga`.

## Interface
- `FIFO_DEPTH`, 8: character queue depth; power of two, minimum 2.
- `FILTER_CYCLES`, 8: consecutive equal samples required before a filtered `ps2_clk` level change is accepted.
- `TIMEOUT_CYCLES`, 50000: idle `clk50M` cycles between PS/2 falling edges that abort a partial frame (1 ms).
- `clk50M` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `kbd_int` out 1: high while the FIFO is non-empty.
- `kbd_data` out 8: ASCII character at the FIFO head; valid while `kbd_int` is high.
- `kbd_int_ack` in 1: consumer acknowledge; each rising edge pops one entry.
- `kbd_overflow` out 1: one-cycle pulse when a character is dropped because the FIFO is full.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - `ps2_clk` is then filtered: the filtered level changes only after `FILTER_CYCLES` identical samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe, and synced `ps2_data` is sampled on that strobe.
- **Receiver FSM** (states IDLE, DATA, PARITY, STOP)
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. Data=1 stays in IDLE.
  - DATA: shift in LSB first; after 8 bits, go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: on `fall`, if the stop bit is 1 and parity passes, emit `byte_valid` for one cycle. Go to IDLE in either case.
  - Timeout: a counter clears on every `fall`. Reaching `TIMEOUT_CYCLES` in any state other than IDLE forces IDLE and discards the partial frame.
- **Decoder** (consumes `byte_valid`)
  - Byte 0xF0 sets `brk`; 0xE0 sets `ext`. Any other byte is processed and then clears both flags.
  - 0x12 and 0x59 set left/right shift on make and clear it on break.
  - 0x58 make toggles `caps`; its break is ignored.
  - Breaks, `ext` codes and unmapped codes produce no character.
  - Letters 0x1C(a), 0x32(b), … 0x1A(z) give lowercase; uppercase when (shift XOR caps).
  - Digit row 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 gives '1'..'9','0'. With shift it gives "!@#$%^&*()". Caps has no effect on digits.
  - Fixed codes: 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09, 0x76→0x1B.
  - A mapped make code issues a one-cycle `push` with the ASCII value.
- **FIFO and handshake**
  - Pointers are log2(`FIFO_DEPTH`) bits wide and wrap modulo depth; an occupancy counter is one bit wider.
  - `kbd_data` is a register loaded from the head entry.
  - `ack_rise` = `kbd_int_ack` & !`ack_d`, where `ack_d` is `kbd_int_ack` registered. `ack_rise` pops when the FIFO is non-empty and is ignored when it is empty.
  - If push and pop coincide, both take effect. This is legal even when the FIFO is full, and occupancy is unchanged.
  - A push while full with no pop in the same cycle drops the character and pulses `kbd_overflow`.
  - Holding `kbd_int_ack` high pops exactly one entry.

## Timing
- Reset values:
  - `kbd_int`=0, `kbd_data`=0x00, `kbd_overflow`=0.
  - FSM=IDLE; FIFO empty.
  - `shift`, `caps`, `brk`, `ext`=0.
  - Synchronizer and filter state are set to 1 (idle bus).
- `rst` mid-frame or with a non-empty FIFO discards everything. No character is emitted for the interrupted frame.
- Latency: `byte_valid` comes 1 cycle after the stop-bit `fall`, then `push` after 1 more cycle. `kbd_int` and `kbd_data` are valid on the cycle after `push`: ≤3 cycles after the stop-bit `fall` strobe.
- Pop: `kbd_int` and `kbd_data` update on the cycle after `ack_rise`. If the FIFO becomes empty, `kbd_int` drops and `kbd_data` holds its last value.

## Configuration
- `KBD_PARITY_CHECK_EN` defined: the STOP check also requires odd parity over the 8 data bits plus the parity bit. Frames that fail are discarded silently.
- Not defined: the parity bit is sampled but ignored; only the start and stop bits are validated.

## Test plan
- Press 'a' (1C, F0 1C) → `kbd_int`=1 with `kbd_data`=0x61; one ack pulse → `kbd_int`=0 next cycle; no second character.
- Shifted and caps input:
  - Sequence 12 1C F0 1C F0 12 → exactly one character, 0x41.
  - Then 58 F0 58 16 F0 16 → 0x31.
  - Then 12 16 → 0x21.
- Nine mapped keys with no ack (`FIFO_DEPTH`=8) → `kbd_overflow` pulses once on the ninth; eight acks return the first eight characters in order, then `kbd_int`=0.
- Simultaneous push and `ack_rise` with the FIFO full → no overflow; occupancy stays 8; order is preserved.
- Frame recovery:
  - Send 5 bits, wait 1.2 ms, then a full 0x29 frame → single 0x20.
  - Assert `rst` mid-frame → no output.
- Frame 0x1C with wrong parity → dropped with `KBD_PARITY_CHECK_EN` defined; 0x61 delivered without it.
